regfile_arbiter: RTL and testbench

- Shares one 16 x 32-bit register file (two combinational read ports, one clocked write port selected by addr0 when ctrw=1) between N_REQ requesters, e.g. core datapath and debug/loader port.
- Round-robin arbitration, valid/ready request handshake, registered one-cycle response, optional lock for multi-transaction bursts.
- Sits between the requesters and the register file; the register file's write strobe is driven only by this block.

---
 rtl/regfile_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 34 +++
 rtl/regfile_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types, default sizes and the address range check for regfile_arbiter.
package regfile_arb_pkg;

  typedef enum logic {ARB, LOCKED} state_t;

  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned AW_DEF       = 8;

  function automatic logic addr_ok(input logic [31:0] addr,
                                   input int unsigned nregs = NUM_REGS_DEF);
    return addr < nregs;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set bit of (valid & mask) at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant
);

  logic [N-1:0] cand;
  logic         found;

  // Two passes: indices from ptr upward, then the wrapped indices below ptr.
  always_comb begin
    cand  = valid & mask;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && cand[i] && (i >= 32'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && cand[i] && (i < 32'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between N_REQ requesters.
// Optional posted-write buffer with forwarding: define REGFILE_ARB_WRITE_FORWARD_EN.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*AW-1:0] req_addr0,
  input  logic [N_REQ*AW-1:0] req_addr1,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic                rsp_err,
  output logic [DW-1:0]       rsp_data0,
  output logic [DW-1:0]       rsp_data1,
  output logic [DW-1:0]       rf_in,
  output logic [AW-1:0]       rf_addr0,
  output logic [AW-1:0]       rf_addr1,
  output logic                rf_ctrw,
  input  logic [DW-1:0]       rf_out0,
  input  logic [DW-1:0]       rf_out1
);

  localparam int unsigned PW = $clog2(N_REQ);

  state_t           state;
  logic [PW-1:0]    rr_ptr, owner, gidx;
  logic [N_REQ-1:0] mask, grant;
  logic             xfer, sel_we, sel_lock, a0_ok, a1_ok, sel_err;
  logic [AW-1:0]    sel_addr0, sel_addr1, addr0_q, addr1_q;
  logic [DW-1:0]    sel_wdata, in_q, rd0, rd1;

  always_comb mask = (state == LOCKED) ? (N_REQ'(1) << owner) : '1;

  rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
    .valid (req_valid & {N_REQ{~rst}}),
    .ptr   (rr_ptr),
    .mask  (mask),
    .grant (grant)
  );

  always_comb begin
    req_ready = grant;
    xfer      = |grant;
    gidx      = '0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr0 = '0;
    sel_addr1 = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx      = PW'(i);
        sel_we    = req_we[i];
        sel_lock  = req_lock[i];
        sel_addr0 = req_addr0[i*AW +: AW];
        sel_addr1 = req_addr1[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
    a0_ok   = addr_ok(32'(sel_addr0), NUM_REGS);
    a1_ok   = addr_ok(32'(sel_addr1), NUM_REGS);
    sel_err = !a0_ok || (!sel_we && !a1_ok);
  end

`ifdef REGFILE_ARB_WRITE_FORWARD_EN
  logic          buf_v, drain, rd_xfer;
  logic [AW-1:0] buf_a;
  logic [DW-1:0] buf_d;

  // rf_addr0 is shared by the write port and read port 0, so a buffered write
  // waits out any read transfer and is forwarded to it meanwhile.
  always_comb begin
    rd_xfer  = xfer && !sel_we;
    drain    = buf_v && !rd_xfer && !rst;
    rf_ctrw  = drain;
    rf_addr0 = drain ? buf_a : (xfer ? sel_addr0 : addr0_q);
    rf_addr1 = xfer ? sel_addr1 : addr1_q;
    rf_in    = drain ? buf_d : (xfer ? sel_wdata : in_q);
    rd0      = (buf_v && (buf_a == sel_addr0)) ? buf_d : rf_out0;
    rd1      = (buf_v && (buf_a == sel_addr1)) ? buf_d : rf_out1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v <= 1'b0;
      buf_a <= '0;
      buf_d <= '0;
    end else if (xfer && sel_we && a0_ok) begin
      buf_v <= 1'b1;
      buf_a <= sel_addr0;
      buf_d <= sel_wdata;
    end else if (drain) begin
      buf_v <= 1'b0;
    end
  end
`else
  always_comb begin
    rf_ctrw  = xfer && sel_we && a0_ok;
    rf_addr0 = xfer ? sel_addr0 : addr0_q;
    rf_addr1 = xfer ? sel_addr1 : addr1_q;
    rf_in    = xfer ? sel_wdata : in_q;
    rd0      = rf_out0;
    rd1      = rf_out1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      owner     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_data0 <= '0;
      rsp_data1 <= '0;
      addr0_q   <= '0;
      addr1_q   <= '0;
      in_q      <= '0;
    end else begin
      addr0_q   <= rf_addr0;
      addr1_q   <= rf_addr1;
      in_q      <= rf_in;
      rsp_valid <= grant;
      rsp_err   <= xfer && sel_err;
      rsp_data0 <= (xfer && !sel_we && !sel_err) ? rd0 : '0;
      rsp_data1 <= (xfer && !sel_we && !sel_err) ? rd1 : '0;
      if (xfer)
        rr_ptr <= (gidx == PW'(N_REQ-1)) ? '0 : gidx + PW'(1);
      case (state)
        ARB: begin
          if (xfer && sel_lock) begin
            state <= LOCKED;
            owner <= gidx;
          end
        end
        LOCKED: begin
          if ((xfer && !sel_lock) || !req_valid[owner])
            state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Table-driven bench for regfile_arbiter with a behavioural 16x32 register file and a response scoreboard.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [15:0] req_addr0, req_addr1;
  logic [63:0] req_wdata;
  logic        rsp_err, rf_ctrw;
  logic [31:0] rsp_data0, rsp_data1, rf_in, rf_out0, rf_out1;
  logic [7:0]  rf_addr0, rf_addr1;

  regfile_arbiter #(.N_REQ(2), .NUM_REGS(16), .DW(32), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rf_in(rf_in), .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_ctrw(rf_ctrw),
    .rf_out0(rf_out0), .rf_out1(rf_out1)
  );

  always #5 clk = ~clk;

  // Register file environment model
  logic [31:0] rf [16];
  always @(posedge clk)
    if (rf_ctrw && rf_addr0 < 8'd16) rf[rf_addr0[3:0]] <= rf_in;
  assign rf_out0 = (rf_addr0 < 8'd16) ? rf[rf_addr0[3:0]] : 32'hBAD0BAD0;
  assign rf_out1 = (rf_addr1 < 8'd16) ? rf[rf_addr1[3:0]] : 32'hBAD1BAD1;

  typedef struct {
    bit          rst;
    bit          zchk;
    logic [1:0]  valid, we, lock, exp;
    logic [7:0]  r0a0, r0a1, r1a0, r1a1;
    logic [31:0] r0wd, r1wd;
  } vec_t;

  typedef struct {
    logic [1:0]  onehot;
    logic        err;
    logic [31:0] d0, d1;
    int          due;
  } exp_t;

  vec_t        vq[$];
  exp_t        sbq[$];
  exp_t        em;
  logic [31:0] exp_rf [16];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          bad_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(input bit r, input logic [1:0] valid, we, lock,
                     input logic [7:0] r0a0, r0a1, input logic [31:0] r0wd,
                     input logic [7:0] r1a0, r1a1, input logic [31:0] r1wd,
                     input logic [1:0] exp, input bit zchk = 0);
    vec_t v;
    v.rst = r; v.valid = valid; v.we = we; v.lock = lock; v.exp = exp; v.zchk = zchk;
    v.r0a0 = r0a0; v.r0a1 = r0a1; v.r0wd = r0wd;
    v.r1a0 = r1a0; v.r1a1 = r1a1; v.r1wd = r1wd;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int row);
    exp_t        e;
    int          r;
    logic [7:0]  a0, a1;
    logic [31:0] wd;
    bit          we;
    rst       = v.rst;
    req_valid = v.valid;
    req_we    = v.we;
    req_lock  = v.lock;
    req_addr0 = {v.r1a0, v.r0a0};
    req_addr1 = {v.r1a1, v.r0a1};
    req_wdata = {v.r1wd, v.r0wd};
    @(negedge clk);
    checks++;
    if (req_ready !== v.exp) begin
      errors++;
      $display("FAIL ready row %0d: got %b want %b", row, req_ready, v.exp);
    end
    if (v.zchk) begin
      checks++;
      if ({rsp_valid, rsp_err, rsp_data0, rsp_data1, rf_ctrw, rf_addr0, rf_addr1, rf_in} !== '0) begin
        errors++;
        $display("FAIL reset_zero row %0d: rsp_valid=%b err=%b d0=%h d1=%h ctrw=%b a0=%h a1=%h in=%h want all 0",
                 row, rsp_valid, rsp_err, rsp_data0, rsp_data1, rf_ctrw, rf_addr0, rf_addr1, rf_in);
      end
    end
    if (!v.rst && v.exp != 2'b00) begin
      r  = v.exp[1] ? 1 : 0;
      we = v.we[r];
      a0 = (r == 1) ? v.r1a0 : v.r0a0;
      a1 = (r == 1) ? v.r1a1 : v.r0a1;
      wd = (r == 1) ? v.r1wd : v.r0wd;
      e.onehot = v.exp;
      e.err    = we ? (a0 >= 8'd16) : (a0 >= 8'd16 || a1 >= 8'd16);
      e.d0     = (we || e.err) ? 32'h0 : exp_rf[a0[3:0]];
      e.d1     = (we || e.err) ? 32'h0 : exp_rf[a1[3:0]];
      e.due    = cyc + 1;
      sbq.push_back(e);
      if (we && a0 < 8'd16) exp_rf[a0[3:0]] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rf_ctrw && rf_addr0 >= 8'd16) bad_wr = 1;
      if (rsp_valid != 2'b00) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b want none", rsp_valid);
        end else begin
          em = sbq.pop_front();
          if (rsp_valid !== em.onehot || rsp_err !== em.err || rsp_data0 !== em.d0 ||
              rsp_data1 !== em.d1 || em.due != cyc) begin
            errors++;
            $display("FAIL rsp cyc %0d: got v=%b e=%b d0=%h d1=%h want v=%b e=%b d0=%h d1=%h at cyc %0d",
                     cyc, rsp_valid, rsp_err, rsp_data0, rsp_data1,
                     em.onehot, em.err, em.d0, em.d1, em.due);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        checks++;
        errors++;
        em = sbq.pop_front();
        $display("FAIL rsp_missing cyc %0d: got none want v=%b", cyc, em.onehot);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf[i]     = (i == 0) ? 32'h0 : (32'hA000_0000 | 32'(i));
      exp_rf[i] = (i == 0) ? 32'h0 : (32'hA000_0000 | 32'(i));
    end
    rst = 1'b1; req_valid = '0; req_we = '0; req_lock = '0;
    req_addr0 = '0; req_addr1 = '0; req_wdata = '0;

    // reset
    add(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    // both valid: grants alternate from requester 0
    for (int i = 0; i < 6; i++)
      add(0, 2'b11, 2'b00, 2'b00, 8'(i), 8'(i + 1), 0, 8'(i + 6), 8'(15 - i), 0,
          (i % 2 == 0) ? 2'b01 : 2'b10);
    // write then read-back
    add(0, 2'b01, 2'b01, 2'b00, 5, 0, 32'hDEADBEEF, 0, 0, 0, 2'b01);
    add(0, 2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 0, 0, 2'b01);
    // range checks and boundaries
    add(0, 2'b01, 2'b00, 2'b00, 16, 0, 0, 0, 0, 0, 2'b01);
    add(0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 200, 0, 32'hCAFEF00D, 2'b10);
    add(0, 2'b01, 2'b00, 2'b00, 2, 17, 0, 0, 0, 0, 2'b01);
    add(0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 15, 99, 32'h0F0F0F0F, 2'b10);
    add(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 15, 15, 0, 2'b10);
    add(0, 2'b11, 2'b00, 2'b00, 1, 2, 0, 3, 4, 0, 2'b01);
    // requester 1 locked for three writes, requester 0 stalled
    add(0, 2'b10, 2'b10, 2'b10, 0, 0, 0, 7, 0, 32'h11111111, 2'b10);
    add(0, 2'b11, 2'b10, 2'b10, 1, 2, 0, 8, 0, 32'h22222222, 2'b10);
    add(0, 2'b11, 2'b10, 2'b00, 1, 2, 0, 9, 0, 32'h33333333, 2'b10);
    add(0, 2'b11, 2'b10, 2'b00, 7, 9, 0, 10, 0, 32'h44444444, 2'b01);
    // lock released by owner dropping valid
    add(0, 2'b01, 2'b00, 2'b01, 8, 5, 0, 0, 0, 0, 2'b01);
    add(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 3, 4, 0, 2'b00);
    add(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 3, 4, 0, 2'b10);
    // reset in the middle of reads
    add(0, 2'b01, 2'b00, 2'b00, 5, 6, 0, 0, 0, 0, 2'b01);
    add(1, 2'b01, 2'b00, 2'b00, 5, 6, 0, 0, 0, 0, 2'b00);
    add(1, 2'b11, 2'b00, 2'b00, 5, 6, 0, 7, 8, 0, 2'b00, 1);
    add(0, 2'b11, 2'b00, 2'b00, 5, 6, 0, 7, 8, 0, 2'b01);
    // read immediately after write to the same register
    add(0, 2'b01, 2'b01, 2'b00, 3, 0, 32'h12345678, 0, 0, 0, 2'b01);
    add(0, 2'b01, 2'b00, 2'b00, 3, 3, 0, 0, 0, 0, 2'b01);
    add(0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 3, 0, 32'h9ABCDEF0, 2'b10);
    add(0, 2'b01, 2'b00, 2'b00, 3, 5, 0, 0, 0, 0, 2'b01);
    add(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 5, 3, 0, 2'b10);
    // idle
    for (int i = 0; i < 3; i++)
      add(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);

    #1;
    foreach (vq[i]) begin
      apply(vq[i], i);
      if (i == 0) mon_en = 1;
    end
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf[i] !== exp_rf[i]) begin
        errors++;
        $display("FAIL rf_contents r%0d: got %h want %h", i, rf[i], exp_rf[i]);
      end
    end
    checks++;
    if (bad_wr) begin
      errors++;
      $display("FAIL rf_ctrw_out_of_range: got strobe on bad address want none");
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL rsp_outstanding: got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
